// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl
//   Button-controlled 14-bit counter feeding the display path. Three raw
//   buttons (run/pause, clear, direction) each pass through a two-flop
//   synchroniser, a debouncer and a registered press-edge detector. A small
//   FSM (IDLE / RUN / PAUSE) gates a prescaler that steps the count value
//   once every TICK_PERIOD = SYS_CLK_HZ / TICK_HZ cycles while running.
//
//   Optional build macro: COUNTER_SATURATE_EN
//     defined   - count stops at the bounds; a step that would wrap leaves
//                 the value unchanged, gives no o_tick and forces PAUSE.
//     undefined - count wraps MAX_VALUE <-> 0.
//
// Ports
//   i_clk        system clock, rising edge
//   i_reset      asynchronous active-low reset
//   i_btn_run    raw run/pause button (active-high, asynchronous)
//   i_btn_clear  raw clear button (active-high, asynchronous)
//   i_btn_dir    raw direction-toggle button (active-high, asynchronous)
//   o_value      current count 0..MAX_VALUE
//   o_running    high while the FSM is in RUN
//   o_dir_down   0 = count up, 1 = count down
//   o_tick       one-cycle pulse in the cycle o_value changes due to a step
//
// State | Meaning
// IDLE  | stopped, prescaler cleared, value 0 after a clear
// RUN   | prescaler counting, value steps at each prescaler wrap
// PAUSE | stopped, value and prescaler held

module counter_run_ctrl #(
  parameter int SYS_CLK_HZ      = 100_000_000,
  parameter int TICK_HZ         = 10,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MAX_VALUE       = 9999
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_btn_run,
  input  logic        i_btn_clear,
  input  logic        i_btn_dir,
  output logic [13:0] o_value,
  output logic        o_running,
  output logic        o_dir_down,
  output logic        o_tick
);

  localparam int TICK_PERIOD = SYS_CLK_HZ / TICK_HZ;
  localparam int PW = (TICK_PERIOD > 2) ? $clog2(TICK_PERIOD) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_PERIOD - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [13:0]   MAX_V      = 14'(MAX_VALUE);

`ifdef COUNTER_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  localparam int B_RUN   = 0;
  localparam int B_CLEAR = 1;
  localparam int B_DIR   = 2;

  // ---------------- button chains ----------------
  logic [2:0]    btn_raw;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    lvl_q, lvl_d, lvl_prev_q;
  logic [2:0]    press_q;
  logic [DW-1:0] db_cnt_q [3];
  logic [DW-1:0] db_cnt_d [3];

  assign btn_raw = {i_btn_dir, i_btn_clear, i_btn_run};

  // The level flips on the cycle the counter would reach DEBOUNCE_CYCLES,
  // i.e. after that many consecutive mismatching samples.
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) lvl_d[i] = sync2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + DW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      press_q    <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
      press_q    <= lvl_q & ~lvl_prev_q;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // ---------------- FSM / prescaler / counter ----------------
  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [13:0]   value_q, value_d, step_val;
  logic          dir_q, dir_d;
  logic          tick_q, tick_d;
  logic          running_q;
  logic          step, at_bound;
  logic          run_p, clear_p;

  assign run_p   = press_q[B_RUN];
  assign clear_p = press_q[B_CLEAR];
  assign step    = (state_q == S_RUN) && (presc_q == PRESC_LAST);

  always_comb begin
    if (dir_q) step_val = (value_q == '0)   ? MAX_V : value_q - 14'd1;
    else       step_val = (value_q == MAX_V) ? '0   : value_q + 14'd1;
    at_bound = SATURATE && (dir_q ? (value_q == '0) : (value_q == MAX_V));
  end

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    tick_d  = 1'b0;
    presc_d = presc_q;
    // A toggle here only lands in dir_q next cycle, so a same-cycle step
    // still uses the old direction.
    dir_d   = dir_q ^ press_q[B_DIR];

    if (state_q == S_RUN) presc_d = step ? '0 : presc_q + PW'(1);

    case (state_q)
      S_IDLE: begin
        if (clear_p)    value_d = '0;
        else if (run_p) state_d = S_RUN;
      end
      S_RUN: begin
        if (clear_p) begin
          state_d = S_IDLE;
          value_d = '0;
        end else begin
          if (step) begin
            if (at_bound) begin
              state_d = S_PAUSE;
            end else begin
              value_d = step_val;
              tick_d  = 1'b1;
            end
          end
          if (run_p) state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (clear_p) begin
          state_d = S_IDLE;
          value_d = '0;
        end else if (run_p) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Clearing on RUN entry places the first step exactly one full period
    // after the entry cycle, including when resuming from PAUSE.
    if (state_d == S_IDLE) presc_d = '0;
    else if (state_d == S_RUN && state_q != S_RUN) presc_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      value_q   <= '0;
      dir_q     <= 1'b0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      value_q   <= value_d;
      dir_q     <= dir_d;
      tick_q    <= tick_d;
      running_q <= (state_d == S_RUN);
    end
  end

  assign o_value    = value_q;
  assign o_running  = running_q;
  assign o_dir_down = dir_q;
  assign o_tick     = tick_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// tb_counter_run_ctrl
//   Self-checking bench for counter_run_ctrl with SYS_CLK_HZ=100, TICK_HZ=10
//   (period 10), DEBOUNCE_CYCLES=4 and MAX_VALUE=12. Expected step values are
//   queued as stimulus is applied; a monitor pops one per o_tick.

module tb_counter_run_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_btn_run, i_btn_clear, i_btn_dir;
  logic [13:0] o_value;
  logic        o_running, o_dir_down, o_tick;

  int n_checks = 0;
  int n_fails  = 0;
  int sb_q[$];

  counter_run_ctrl #(
    .SYS_CLK_HZ(100), .TICK_HZ(10), .DEBOUNCE_CYCLES(4), .MAX_VALUE(12)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_btn_run(i_btn_run), .i_btn_clear(i_btn_clear), .i_btn_dir(i_btn_dir),
    .o_value(o_value), .o_running(o_running), .o_dir_down(o_dir_down),
    .o_tick(o_tick)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic wait_tick(input int v);
    int n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!(o_tick && o_value == 14'(v)) && n < 200);
    if (!(o_tick && o_value == 14'(v)))
      chk("wait_tick", 32'({o_tick, o_value}), 32'({1'b1, 14'(v)}));
  endtask

  // Scoreboard monitor: every step pulse must match the next queued value.
  initial begin
    int e;
    forever begin
      @(negedge i_clk);
      if (i_reset && o_tick) begin
        if (sb_q.size() == 0) begin
          chk("spurious_tick", 32'(o_tick), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("tick_value", 32'(o_value), 32'(e));
        end
      end
    end
  end

  initial begin
    i_reset = 1'b1; i_btn_run = 1'b0; i_btn_clear = 1'b0; i_btn_dir = 1'b0;
    #1 i_reset = 1'b0;
    #2;
    chk("rst_value",   32'(o_value),    32'd0);
    chk("rst_running", 32'(o_running),  32'd0);
    chk("rst_dir",     32'(o_dir_down), 32'd0);
    chk("rst_tick",    32'(o_tick),     32'd0);
    cyc(3);
    i_reset = 1'b1;
    cyc(3);

    // Short glitch on run never survives the debouncer.
    i_btn_run = 1'b1; cyc(3); i_btn_run = 1'b0; cyc(20);
    chk("glitch_running", 32'(o_running), 32'd0);
    chk("glitch_value",   32'(o_value),   32'd0);

    // Run press: pulse 7 cycles after the raw edge, RUN the cycle after,
    // first step 10 cycles after RUN entry.
    for (int v = 1; v <= 5; v++) sb_q.push_back(v);
    i_btn_run = 1'b1;
    cyc(7);  chk("run_lat_pre",  32'(o_running), 32'd0);
    cyc(1);  chk("run_lat",      32'(o_running), 32'd1);
    cyc(9);  chk("first_tick_pre", 32'(o_tick),  32'd0);
    cyc(1);  chk("first_tick",   32'(o_tick),    32'd1);
    cyc(2);  i_btn_run = 1'b0;
    wait_tick(5);

    // Pause right after a step, hold for 50 cycles.
    i_btn_run = 1'b1;
    cyc(8);  chk("pause_running", 32'(o_running), 32'd0);
    cyc(2);  i_btn_run = 1'b0;
    cyc(40); chk("pause_hold",   32'(o_value),   32'd5);

    // Resume: prescaler restarts, next step exactly 10 cycles after entry.
    sb_q.push_back(6);
    i_btn_run = 1'b1;
    cyc(8);  chk("resume_running", 32'(o_running), 32'd1);
    cyc(9);  chk("resume_tick_pre", 32'(o_tick),   32'd0);
    cyc(1);  chk("resume_tick",     32'(o_tick),   32'd1);
    i_btn_run = 1'b0;

    for (int v = 7; v <= 12; v++) sb_q.push_back(v);
`ifdef COUNTER_SATURATE_EN
    wait_tick(12);
    cyc(11);
    chk("sat_running", 32'(o_running), 32'd0);
    chk("sat_value",   32'(o_value),   32'd12);
    i_btn_dir = 1'b1; cyc(10); i_btn_dir = 1'b0; cyc(10);
    chk("sat_dir", 32'(o_dir_down), 32'd1);
    sb_q.push_back(11); sb_q.push_back(10);
    i_btn_run = 1'b1; cyc(10); i_btn_run = 1'b0;
    wait_tick(10);
`else
    sb_q.push_back(0);
    wait_tick(12);
    wait_tick(0);
    // Direction toggles before the next step; wraps 0 -> 12 downward.
    sb_q.push_back(12); sb_q.push_back(11);
    i_btn_dir = 1'b1;
    cyc(8);  chk("dir_toggle", 32'(o_dir_down), 32'd1);
    cyc(2);  i_btn_dir = 1'b0;
    wait_tick(11);
`endif

    // Run and clear pulse together: clear wins.
    i_btn_run = 1'b1; i_btn_clear = 1'b1;
    cyc(8);
    chk("clr_running", 32'(o_running), 32'd0);
    chk("clr_value",   32'(o_value),   32'd0);
    chk("clr_tick",    32'(o_tick),    32'd0);
    cyc(2); i_btn_run = 1'b0; i_btn_clear = 1'b0;
    cyc(12);
    chk("clr_value_hold", 32'(o_value), 32'd0);

    // Direction press in IDLE restores up-counting.
    i_btn_dir = 1'b1; cyc(10); i_btn_dir = 1'b0; cyc(10);
    chk("idle_dir", 32'(o_dir_down), 32'd0);

    for (int v = 1; v <= 7; v++) sb_q.push_back(v);
    i_btn_run = 1'b1; cyc(10); i_btn_run = 1'b0;
    wait_tick(7);
    i_btn_dir = 1'b1;
    cyc(8);  chk("pre_rst_dir", 32'(o_dir_down), 32'd1);
    // Reset mid-cycle: outputs must clear before the next clock edge.
    #2 i_reset = 1'b0;
    #1;
    chk("arst_value",   32'(o_value),    32'd0);
    chk("arst_running", 32'(o_running),  32'd0);
    chk("arst_dir",     32'(o_dir_down), 32'd0);
    chk("arst_tick",    32'(o_tick),     32'd0);
    i_btn_dir = 1'b0;
    cyc(3);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
